sdf_fifo: RTL and testbench
===========================

# sdf_fifo

Parametrised synchronous FIFO for the pipelined FFT datapath. It generalises the fixed 32-entry, 11-bit stage buffer to any power-of-two depth and any width. It adds full/empty/almost-full status, an occupancy count, a synchronous flush and a registered read port. One instance sits between each pair of butterfly stages and buffers the feedback samples of an SDF stage.

## Interface
Parameters:
- WIDTH, 11: data word width in bits (≥1).
- DEPTH, 32: number of entries; power of two, ≥2.
- AFULL, DEPTH-2: almost_full asserts when count ≥ AFULL; legal range 1..DEPTH.
- AW, derived = log2(DEPTH): pointer width; not to be overridden.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset; **asynchronous, active-high**.
- flush  in  1  synchronous clear of pointers, count and valid.
- w_en  in  1  write request.
- data_in  in  WIDTH  write data.
- r_en  in  1  read request.
- data_out  out  WIDTH  read data; registered.
- out_valid  out  1  data_out holds a word popped on the previous cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL.
- count  out  AW+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky overflow error.
- udf  out  1  sticky underflow error.
- clr_err  in  1  synchronous clear of ovf/udf.

## Operation
- Reset values: data_out=0, out_valid=0, full=0, empty=1, almost_full=0, count=0, ovf=0, udf=0. Pointers are zero at reset. Storage is not reset.
- Write accepted (wa) = w_en & (!full | r_en). Write is accepted on a full FIFO only when a read occurs in the same cycle.
- Read accepted (ra) = r_en & !empty. A read on an empty FIFO is never accepted, even with a simultaneous write. There is no bypass.
- wa: mem[wptr] ← data_in, wptr ← wptr+1 mod DEPTH. ra: rptr ← rptr+1 mod DEPTH. Pointers wrap naturally at AW bits.
- count ← count + wa − ra. It is unchanged when both occur.
- full, empty and almost_full are registered and derived from next count, so they are valid in the same cycle as count.
- data_out ← mem[rptr] and out_valid ← 1 on ra. Otherwise data_out ← 0 and out_valid ← 0; the idle output is zero.
- ovf set when w_en & full & !r_en. udf set when r_en & empty. Both are sticky until clr_err or rst. If clr_err coincides with a new error event, the flag stays set (set wins).
- flush: pointers, count and out_valid ← 0; data_out ← 0; empty=1, full=0. w_en/r_en in the same cycle are ignored. Error flags are unaffected.
- Arithmetic: count is AW+1 bits unsigned and never exceeds DEPTH. No saturation logic is needed because acceptance gating prevents it.

## Timing
- Write-to-read latency: a word written in cycle n is readable with r_en in cycle n+1. It appears on data_out in cycle n+2.
- Read latency: one cycle from accepted r_en to data_out/out_valid.
- Back-to-back reads and writes are sustained at one word per cycle with no bubbles.
- Asynchronous rst assertion mid-operation forces all outputs to reset values immediately. Deassertion is assumed to be synchronised externally. Contents are undefined after reset and must not be observed (empty=1 guarantees this).

## Configuration
- SDF_FIFO_ERR_EN defined: ovf/udf logic and clr_err are implemented as above.
- SDF_FIFO_ERR_EN undefined: ovf and udf are tied to 0, clr_err is ignored, and no error flops are synthesised. Port list is identical in both builds.

## Structure
- Shared package sdf_pkg holds:
  - the default data-width constant (11);
  - a constant log2 function used to derive AW;
  - an elaboration check helper asserting that DEPTH is a power of two.
- One sub-module, sdf_fifo_ram: simple dual-port RAM of DEPTH×WIDTH with one write port and a registered read port (read enable, address). The top level holds pointers, count, flags and errors.

## Test plan
- After reset, 5 writes of 0x001..0x005 then 5 reads → data_out 0x001..0x005 in order, each one cycle after r_en; count goes 5→0; empty=1 at end.
- Fill 32 words (defaults): full=1, almost_full from count 30. A 33rd write without read → count stays 32 and ovf=1 (ERR_EN). A clr_err pulse then clears ovf.
- Full FIFO with w_en=r_en=1 for 40 cycles → count stays 32, no ovf, and outputs match input order across pointer wrap.
- Empty FIFO with r_en=1, w_en=1, data 0x7FF → read not accepted, out_valid=0, data_out=0, udf=1, count=1. Next cycle's read returns 0x7FF.
- 10 words written, then flush with w_en=1 in the same cycle → count=0, empty=1, data_out=0; the write is dropped, and a subsequent read is not accepted.
- rst asserted mid-stream with count=17 → all outputs reset immediately, without waiting for a clock edge. Rebuild with SDF_FIFO_ERR_EN undefined and repeat the overflow scenario → ovf stays 0.

Source files
------------

// File: rtl/sdf_pkg.sv
// Shared constants and elaboration helpers for the SDF FFT stage buffers.
package sdf_pkg;

    localparam int SDF_DATA_W = 11;

    // Ceiling log2, evaluated at elaboration to size pointers.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sdf_fifo_ram.sv
// Simple dual-port DEPTHxWIDTH storage: one write port, one registered read port.
module sdf_fifo_ram
    import sdf_pkg::*;
#(
    parameter int WIDTH = SDF_DATA_W,
    parameter int DEPTH = 32,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sdf_fifo.sv
// Parametrised synchronous FIFO buffering SDF feedback samples between butterfly stages.
// Optional sticky overflow/underflow flags are built when SDF_FIFO_ERR_EN is defined.
module sdf_fifo
    import sdf_pkg::*;
#(
    parameter int WIDTH = SDF_DATA_W,
    parameter int DEPTH = 32,
    parameter int AFULL = DEPTH - 2,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             w_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             udf,
    input  logic             clr_err
);

    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("sdf_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL < 1 || AFULL > DEPTH) begin : g_afull_chk
        $error("sdf_fifo: AFULL must lie in 1..DEPTH");
    end

    logic [AW-1:0]    wptr, rptr;
    logic             wa, ra;
    logic [AW:0]      count_nxt;
    logic             vld_p1;
    logic [WIDTH-1:0] ram_q_p1;

    assign wa        = w_en & (~full | r_en);
    assign ra        = r_en & ~empty;
    assign count_nxt = count + (AW+1)'(wa) - (AW+1)'(ra);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            vld_p1      <= 1'b0;
        end else if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            if (wa) begin
                wptr <= wptr + AW'(1);
            end
            if (ra) begin
                rptr <= rptr + AW'(1);
            end
            count       <= count_nxt;
            full        <= (count_nxt == (AW+1)'(DEPTH));
            empty       <= (count_nxt == '0);
            almost_full <= (count_nxt >= (AW+1)'(AFULL));
            vld_p1      <= ra;
        end
    end

    sdf_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wa & ~flush),
        .waddr (wptr),
        .wdata (data_in),
        .re    (ra & ~flush),
        .raddr (rptr),
        .rdata (ram_q_p1)
    );

    // ---- stage p1: read word leaves the RAM register; idle cycles present zero ----
    assign out_valid = vld_p1;
    assign data_out  = vld_p1 ? ram_q_p1 : '0;

`ifdef SDF_FIFO_ERR_EN
    logic ovf_set, udf_set;

    assign ovf_set = w_en & full & ~r_en & ~flush;
    assign udf_set = r_en & empty & ~flush;

    // Set has priority over clear so a coincident event is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~clr_err);
            udf <= udf_set | (udf & ~clr_err);
        end
    end
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign ovf            = 1'b0;
    assign udf            = 1'b0;
`endif

endmodule

// File: tb/tb_sdf_fifo.sv
// Directed table-driven bench for sdf_fifo with default parameters.
module tb_sdf_fifo;

`ifdef SDF_FIFO_ERR_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        w_en;
    logic [10:0] data_in;
    logic        r_en;
    logic [10:0] data_out;
    logic        out_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic [5:0]  count;
    logic        ovf;
    logic        udf;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    sdf_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .w_en        (w_en),
        .data_in     (data_in),
        .r_en        (r_en),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .ovf         (ovf),
        .udf         (udf),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic        r;
        logic        fl;
        logic        clr;
        logic [10:0] din;
        logic [10:0] dout;
        logic        vld;
        int          cnt;
        logic        emp;
        logic        udf;
    } vec_t;

    vec_t       tbl[13];
    logic [10:0] q[$];
    logic [10:0] exp_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " count"}, 32'(count), 32'd0);
        chk({tag, " empty"}, 32'(empty), 32'd1);
        chk({tag, " full"}, 32'(full), 32'd0);
        chk({tag, " afull"}, 32'(almost_full), 32'd0);
        chk({tag, " vld"}, 32'(out_valid), 32'd0);
        chk({tag, " dout"}, 32'(data_out), 32'd0);
        chk({tag, " ovf"}, 32'(ovf), 32'd0);
        chk({tag, " udf"}, 32'(udf), 32'd0);
    endtask

    initial begin
        // Five writes, five reads, empty read with write, then a clr_err pulse.
        for (int i = 0; i < 5; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'(i + 1), 11'h000, 1'b0, i + 1, 1'b0, 1'b0};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'(i - 4), 1'b1, 9 - i, (i == 9), 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 11'h7FF, 11'h000, 1'b0, 1, 1'b0, E};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h7FF, 1'b1, 0, 1'b1, E};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 11'h000, 1'b0, 0, 1'b1, 1'b0};

        rst = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            w_en = tbl[i].w; r_en = tbl[i].r; flush = tbl[i].fl;
            clr_err = tbl[i].clr; data_in = tbl[i].din;
            step();
            chk($sformatf("v%0d dout", i), 32'(data_out), 32'(tbl[i].dout));
            chk($sformatf("v%0d vld", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("v%0d udf", i), 32'(udf), 32'(tbl[i].udf));
        end
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;

        // Fill to 32 entries, watching full and almost_full thresholds.
        for (int i = 0; i < 32; i++) begin
            w_en = 1'b1; data_in = 11'(12'h100 + i);
            q.push_back(data_in);
            step();
            chk($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill%0d full", i), 32'(full), 32'(i + 1 == 32));
            chk($sformatf("fill%0d afull", i), 32'(almost_full), 32'(i + 1 >= 30));
        end
        data_in = 11'h3FF;
        step();
        chk("ovf count", 32'(count), 32'd32);
        chk("ovf full", 32'(full), 32'd1);
        chk("ovf flag", 32'(ovf), 32'(E));
        w_en = 1'b0; clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf cleared", 32'(ovf), 32'd0);

        // Simultaneous read/write on a full FIFO across pointer wrap.
        w_en = 1'b1; r_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            data_in = 11'(12'h200 + k);
            exp_w = q.pop_front();
            q.push_back(data_in);
            step();
            chk($sformatf("rw%0d dout", k), 32'(data_out), 32'(exp_w));
            chk($sformatf("rw%0d vld", k), 32'(out_valid), 32'd1);
            chk($sformatf("rw%0d count", k), 32'(count), 32'd32);
            chk($sformatf("rw%0d ovf", k), 32'(ovf), 32'd0);
        end
        w_en = 1'b0; r_en = 1'b0;
        step();
        chk("idle vld", 32'(out_valid), 32'd0);
        chk("idle dout", 32'(data_out), 32'd0);

        // Flush: clear, write ten, flush with a concurrent write, then read.
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush0 count", 32'(count), 32'd0);
        chk("flush0 empty", 32'(empty), 32'd1);
        q.delete();
        for (int i = 0; i < 10; i++) begin
            w_en = 1'b1; data_in = 11'(8'h40 + i);
            step();
        end
        chk("pre-flush count", 32'(count), 32'd10);
        flush = 1'b1; w_en = 1'b1; data_in = 11'h555;
        step();
        flush = 1'b0; w_en = 1'b0;
        chk("flush count", 32'(count), 32'd0);
        chk("flush empty", 32'(empty), 32'd1);
        chk("flush full", 32'(full), 32'd0);
        chk("flush dout", 32'(data_out), 32'd0);
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        chk("post-flush vld", 32'(out_valid), 32'd0);
        chk("post-flush dout", 32'(data_out), 32'd0);
        chk("post-flush count", 32'(count), 32'd0);
        chk("post-flush udf", 32'(udf), 32'(E));

        // Asynchronous reset mid-stream with count 17 and a valid output word.
        for (int i = 0; i < 18; i++) begin
            w_en = 1'b1; data_in = 11'(8'h60 + i);
            step();
        end
        w_en = 1'b0; r_en = 1'b1;
        step();
        r_en = 1'b0;
        chk("pre-rst count", 32'(count), 32'd17);
        chk("pre-rst vld", 32'(out_valid), 32'd1);
        chk("pre-rst dout", 32'(data_out), 32'h60);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("async");
        step();
        rst = 1'b0;
        step();
        chk("after-rst count", 32'(count), 32'd0);
        chk("after-rst empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
